tl_light_monitor: RTL
=====================

Name: tl_light_monitor

Overview:
- Observer on the traffic-light controller's lamp outputs. Performs the inverse of the state-to-lamp output logic.
- Samples the two 2-bit lamp codes La/Lb and reconstructs the controller's 3-bit state. Two yellow codes are ambiguous, so history resolves them.
- Checks sequence legality and measures per-state dwell time.
- Sits beside the controller in the lab top level. Used as a built-in checker and as a debug/readout source.

Parameters:
- CNT_W, 8, width of dwell counter (saturating)
- MIN_DWELL, 2, minimum samples a state must be held before advancing; must be at least 1

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- La  input  2  street-A lamp code from controller
- Lb  input  2  street-B lamp code from controller
- clr_err  input  1  synchronous clear of sticky error, level, one cycle enough
- state_q  output  3  reconstructed controller state 0..7
- locked  output  1  state_q is valid
- dwell  output  CNT_W  samples spent in current state_q, including entry sample
- round_cnt  output  8  completed full cycles (7->0 advances), wraps 255->0
- err  output  1  sticky error flag
- err_code  output  2  cause of first error since last clear: 00 none, 01 illegal code, 10 illegal transition, 11 short dwell

Behaviour:
- Lamp codes: 00 green, 01 yellow, 10 left-turn, 11 red.
- Expected (La,Lb) per state:
  - 0=(00,11), 1=(01,11), 2=(10,11), 3=(01,11)
  - 4=(11,00), 5=(11,01), 6=(11,10), 7=(11,01)
- Code classes:
  - Unambiguous: states 0,2,4,6.
  - Ambiguous: (01,11) is state 1 or 3; (11,01) is state 5 or 7.
  - Illegal: every other pair, e.g. (11,11) or both non-red.
- Reset (async, reset_n=0): state_q=0, locked=0, dwell=0, round_cnt=0, err=0, err_code=00, internal first_seg=1.
- Timing: La/Lb are sampled on every rising edge. All outputs are registered and reflect the sample one cycle later.
- FSM states:
  - SYNC:
    - locked=0, state_q holds 0, dwell=0.
    - Unambiguous code -> TRACK, state_q=decoded value, dwell=1, first_seg=1.
    - Ambiguous code -> stay in SYNC, no error.
    - Illegal code -> error 01, stay in SYNC.
  - TRACK:
    - locked=1.
    - Sample matches state_q (hold) -> dwell+1, saturating at 2^CNT_W-1.
    - Sample matches (state_q+1) mod 8 (advance) -> state_q increments, dwell=1, first_seg=0. Ambiguous codes resolve to the +1 candidate here.
    - Short dwell: on an advance with first_seg=0 and old dwell < MIN_DWELL -> error 11. Tracking still advances and stays locked.
    - Advance from 7 to 0 -> round_cnt+1, mod 256.
    - Legal code that is neither hold nor advance -> error 10, go to SYNC.
    - Illegal code -> error 01, go to SYNC.
    - On either exit to SYNC: locked=0, dwell=0, state_q=0 on the next cycle. Relock happens at the earliest following sample.
- Error register:
  - err sets on any error. err_code latches only when err was 0, so the first cause is kept.
  - clr_err=1 -> err=0, err_code=00 next cycle.
  - clr_err and a new error in the same cycle: the new error wins (err=1, new code).
  - clr_err does not affect FSM, dwell or round_cnt.
- No short-dwell check on the first state after lock (first_seg=1), because its entry is unobserved.
- Reset asserted mid-operation forces all reset values immediately. After release the block starts in SYNC.

Decomposition:
- Shared package tl_pkg:
  - lamp codes LAMP_G, LAMP_Y, LAMP_L, LAMP_R
  - state constants S0..S7
  - error codes E_NONE, E_CODE, E_TRANS, E_SHORT
  - FSM encoding SYNC/TRACK
  - the state->(La,Lb) mapping, so the controller's output logic and the monitor share one table
- One sub-module, tl_code_dec (combinational):
  - input (La,Lb)
  - outputs legal, ambig, base_state[2:0]
  - for ambiguous codes base_state gives the lower candidate (1 or 5)

Test Plan (CNT_W=8, MIN_DWELL=2):
- Reset, then drive states 0..7 in order, each held 3 cycles. Expect lock after the first (00,11) sample, state_q sequence 0..7, dwell counting 1,2,3, err=0, round_cnt=1 after the 7->0 advance.
- Start with (01,11) for 4 cycles, then (10,11). Expect locked=0 with no error, then lock with state_q=2. A subsequent (01,11) must decode as 3.
- While locked in state 2, drive (00,11). Expect err=1, err_code=10, locked=0 next cycle. Then (00,11) relocks to state 0.
- While locked, drive (11,11). Expect err_code=01 and an unlock. Then drive a (00,10) illegal code. err_code must stay 01 (first cause kept).
- Hold state 4 for 3 cycles, state 5 for 1 cycle, then state 6. Expect err_code=11 on the 5->6 advance, locked stays 1, state_q=6.
- Assert clr_err in the same cycle as an illegal code. Expect err=1, code 01. Separately, assert clr_err alone: err=0, code 00. Hold one state 300 cycles: dwell saturates at 255. Assert reset_n=0 mid-run: all outputs reset asynchronously.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller and its lamp monitor.
// Contents:
//   lamp_t    - 2-bit lamp codes (green, yellow, left-turn, red)
//   S0..S7    - controller state constants
//   err_t     - monitor error causes
//   fsm_t     - monitor tracking FSM encoding
//   lamp_code - state -> {La, Lb}. The controller's output logic and the
//               monitor's decoder both use this one table.
package tl_pkg;

    typedef enum logic [1:0] {
        LAMP_G = 2'b00,
        LAMP_Y = 2'b01,
        LAMP_L = 2'b10,
        LAMP_R = 2'b11
    } lamp_t;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    typedef enum logic [1:0] {
        E_NONE  = 2'b00,
        E_CODE  = 2'b01,
        E_TRANS = 2'b10,
        E_SHORT = 2'b11
    } err_t;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } fsm_t;

    // Returns {La, Lb} for a controller state.
    function automatic logic [3:0] lamp_code(input logic [2:0] s);
        logic [3:0] code;
        case (s)
            S0:      code = {LAMP_G, LAMP_R};
            S1:      code = {LAMP_Y, LAMP_R};
            S2:      code = {LAMP_L, LAMP_R};
            S3:      code = {LAMP_Y, LAMP_R};
            S4:      code = {LAMP_R, LAMP_G};
            S5:      code = {LAMP_R, LAMP_Y};
            S6:      code = {LAMP_R, LAMP_L};
            default: code = {LAMP_R, LAMP_Y};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tl_code_dec.sv
// Combinational inverse of the controller's lamp-output table.
// Ports:
//   La, Lb     in  2  lamp codes
//   legal      out 1  pair belongs to at least one state
//   ambig      out 1  pair belongs to two states (1/3 or 5/7)
//   base_state out 3  matching state; the lower candidate when ambig
module tl_code_dec
    import tl_pkg::*;
(
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       legal,
    output logic       ambig,
    output logic [2:0] base_state
);

    // Scan from the top so the last match written is the lowest state;
    // a second hit marks the pair as ambiguous.
    always_comb begin
        legal      = 1'b0;
        ambig      = 1'b0;
        base_state = 3'd0;
        for (int s = 7; s >= 0; s--) begin
            if (lamp_code(3'(s)) == {La, Lb}) begin
                ambig      = legal;
                legal      = 1'b1;
                base_state = 3'(s);
            end
        end
    end

endmodule

// File: rtl/tl_light_monitor.sv
// Lamp-output observer for the traffic-light controller. Reconstructs the
// controller state from (La, Lb), checks sequence legality and measures
// how long each state is held.
// Ports:
//   clk        in  1      rising-edge clock
//   reset_n    in  1      asynchronous active-low reset
//   La, Lb     in  2      lamp codes from controller
//   clr_err    in  1      synchronous clear of the sticky error
//   state_q    out 3      reconstructed state
//   locked     out 1      state_q is valid
//   dwell      out CNT_W  samples in current state (saturating)
//   round_cnt  out 8      completed 7->0 advances, wrapping
//   err        out 1      sticky error flag
//   err_code   out 2      first error cause since last clear
module tl_light_monitor
    import tl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             clr_err,
    output logic [2:0]       state_q,
    output logic             locked,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       round_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    logic             legal;
    logic             ambig;
    logic [2:0]       base_state;

    fsm_t             fsm_q, fsm_d;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] dwell_d;
    logic             first_seg_q, first_seg_d;
    logic [7:0]       round_d;
    logic             err_d;
    err_t             code_q, code_d;

    logic             new_err;
    err_t             new_code;
    logic [2:0]       next_state;
    logic [2:0]       alt_state;
    logic             hold;
    logic             adv;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    tl_code_dec u_dec (
        .La         (La),
        .Lb         (Lb),
        .legal      (legal),
        .ambig      (ambig),
        .base_state (base_state)
    );

    // An ambiguous pair matches both base_state and base_state+2, so a
    // state matches if it equals either candidate. Hold and advance cannot
    // both match since the candidates are two apart.
    assign alt_state  = base_state + 3'd2;
    assign next_state = state_q + 3'd1;
    assign hold = legal && ((state_q == base_state) || (ambig && state_q == alt_state));
    assign adv  = legal && ((next_state == base_state) || (ambig && next_state == alt_state));

    assign locked   = (fsm_q == TRACK);
    assign err_code = code_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= SYNC;
            state_q     <= 3'd0;
            dwell       <= '0;
            first_seg_q <= 1'b1;
            round_cnt   <= 8'd0;
            err         <= 1'b0;
            code_q      <= E_NONE;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            dwell       <= dwell_d;
            first_seg_q <= first_seg_d;
            round_cnt   <= round_d;
            err         <= err_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        dwell_d     = dwell;
        first_seg_d = first_seg_q;
        round_d     = round_cnt;
        new_err     = 1'b0;
        new_code    = E_NONE;

        case (fsm_q)
            SYNC: begin
                if (!legal) begin
                    new_err  = 1'b1;
                    new_code = E_CODE;
                end else if (!ambig) begin
                    fsm_d       = TRACK;
                    state_d     = base_state;
                    dwell_d     = CNT_W'(1);
                    first_seg_d = 1'b1;
                end
            end
            default: begin
                if (!legal) begin
                    new_err  = 1'b1;
                    new_code = E_CODE;
                    fsm_d    = SYNC;
                    state_d  = 3'd0;
                    dwell_d  = '0;
                end else if (hold) begin
                    dwell_d = sat_inc(dwell);
                end else if (adv) begin
                    // The first segment after lock has an unseen entry, so
                    // its dwell is not a real measurement.
                    if (!first_seg_q && dwell < CNT_W'(MIN_DWELL)) begin
                        new_err  = 1'b1;
                        new_code = E_SHORT;
                    end
                    if (state_q == S7) begin
                        round_d = round_cnt + 8'd1;
                    end
                    state_d     = next_state;
                    dwell_d     = CNT_W'(1);
                    first_seg_d = 1'b0;
                end else begin
                    new_err  = 1'b1;
                    new_code = E_TRANS;
                    fsm_d    = SYNC;
                    state_d  = 3'd0;
                    dwell_d  = '0;
                end
            end
        endcase
    end

    // Sticky error: clear first, then a new error overrides the clear.
    // The code only latches when the flag is (effectively) clear, so the
    // first cause survives until software clears it.
    always_comb begin
        err_d  = err;
        code_d = code_q;
        if (clr_err) begin
            err_d  = 1'b0;
            code_d = E_NONE;
        end
        if (new_err) begin
            if (!err || clr_err) begin
                code_d = new_code;
            end
            err_d = 1'b1;
        end
    end

endmodule
